// File: rtl/tcdm_bank_responder.sv
// Memory-side responder for one TCDM bank: flop-based word array with
// 1-cycle read latency and an in-order response buffer behind it.
module tcdm_bank_responder #(
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned TagWidth   = 4,
    parameter int unsigned RespDepth  = 2,
    localparam int unsigned BeWidth    = DataWidth / 8,
    localparam int unsigned WAddrWidth = $clog2(NumWords)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [WAddrWidth-1:0] req_addr_i,
    input  logic                  req_wen_i,
    input  logic [BeWidth-1:0]    req_be_i,
    input  logic [DataWidth-1:0]  req_wdata_i,
    input  logic [TagWidth-1:0]   req_tag_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DataWidth-1:0]  resp_rdata_o,
    output logic                  resp_wen_o,
    output logic [TagWidth-1:0]   resp_tag_o
);

    localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW = $clog2(RespDepth + 1);

    logic [DataWidth-1:0] mem_q [NumWords];

    logic                 infl_q, infl_d;
    logic [DataWidth-1:0] infl_rdata_q;
    logic                 infl_wen_q;
    logic [TagWidth-1:0]  infl_tag_q;

    logic [DataWidth-1:0] buf_rdata_q [RespDepth];
    logic                 buf_wen_q   [RespDepth];
    logic [TagWidth-1:0]  buf_tag_q   [RespDepth];

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW:0]   occupancy;

    logic accept;
    logic buf_empty;
    logic resp_pop;
    logic buf_push;
    logic buf_pop;

    // Occupancy counts the access in flight so a slot is reserved for its
    // response before it reaches the buffer.
    assign occupancy   = {1'b0, count_q} + (CntW + 1)'(infl_q);
    assign req_ready_o = occupancy < (CntW + 1)'(RespDepth);
    assign accept      = req_valid_i & req_ready_o;

    assign buf_empty = (count_q == '0);
    assign resp_pop  = resp_valid_o & resp_ready_i;
    // With an empty buffer the in-flight response is shown directly; if it is
    // consumed in that cycle it never needs a buffer slot.
    assign buf_push  = infl_q & ~(buf_empty & resp_pop);
    assign buf_pop   = resp_pop & ~buf_empty;

    always_ff @(posedge clk_i) begin
        if (accept && req_wen_i && !rst_i) begin
            for (int i = 0; i < int'(BeWidth); i++) begin
                if (req_be_i[i]) begin
                    mem_q[req_addr_i][i*8 +: 8] <= req_wdata_i[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            infl_rdata_q <= req_wen_i ? '0 : mem_q[req_addr_i];
            infl_wen_q   <= req_wen_i;
            infl_tag_q   <= req_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_push) begin
            buf_rdata_q[wptr_q] <= infl_rdata_q;
            buf_wen_q[wptr_q]   <= infl_wen_q;
            buf_tag_q[wptr_q]   <= infl_tag_q;
        end
    end

    always_comb begin
        infl_d  = accept;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CntW'(buf_push) - CntW'(buf_pop);
        if (buf_push) begin
            wptr_d = (wptr_q == PtrW'(RespDepth - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (buf_pop) begin
            rptr_d = (rptr_q == PtrW'(RespDepth - 1)) ? '0 : rptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            infl_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            infl_q  <= infl_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_wen_o   = 1'b0;
        resp_tag_o   = '0;
        if (!buf_empty) begin
            resp_valid_o = 1'b1;
            resp_rdata_o = buf_rdata_q[rptr_q];
            resp_wen_o   = buf_wen_q[rptr_q];
            resp_tag_o   = buf_tag_q[rptr_q];
        end else if (infl_q) begin
            resp_valid_o = 1'b1;
            resp_rdata_o = infl_rdata_q;
            resp_wen_o   = infl_wen_q;
            resp_tag_o   = infl_tag_q;
        end
    end

`ifndef SYNTHESIS
    a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
        !(buf_push && (count_q == CntW'(RespDepth))));
    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (rst_i)
        !(buf_pop && buf_empty));
    a_addr_known : assert property (@(posedge clk_i) disable iff (rst_i)
        req_valid_i |-> !$isunknown(req_addr_i));
`endif

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Randomized and directed bench for tcdm_bank_responder against a queue-based
// model of the bank contents and outstanding responses.
module tb_tcdm_bank_responder;

    localparam int NW = 1024;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int D  = 2;
    localparam int AW = 10;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready_o;
    logic [AW-1:0] req_addr;
    logic          req_wen;
    logic [BW-1:0] req_be;
    logic [DW-1:0] req_wdata;
    logic [TW-1:0] req_tag;
    logic          resp_valid_o;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata_o;
    logic          resp_wen_o;
    logic [TW-1:0] resp_tag_o;

    always #5 clk = ~clk;

    tcdm_bank_responder #(
        .NumWords(NW), .DataWidth(DW), .TagWidth(TW), .RespDepth(D)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr), .req_wen_i(req_wen), .req_be_i(req_be),
        .req_wdata_i(req_wdata), .req_tag_i(req_tag),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata_o), .resp_wen_o(resp_wen_o),
        .resp_tag_o(resp_tag_o)
    );

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          wen;
        logic [TW-1:0] tag;
    } resp_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [DW-1:0] mem_m [NW];
    resp_t         exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outstanding responses = accepted and not yet consumed; the head of that
    // list is what must be on the response port.
    task automatic check_outputs();
        resp_t e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q[0];
        chk("resp_valid", 64'(resp_valid_o), 64'(exp_q.size() > 0));
        chk("req_ready",  64'(req_ready_o),  64'(exp_q.size() < D));
        chk("resp_rdata", 64'(resp_rdata_o), 64'(e.rdata));
        chk("resp_wen",   64'(resp_wen_o),   64'(e.wen));
        chk("resp_tag",   64'(resp_tag_o),   64'(e.tag));
    endtask

    // Called at a falling edge with inputs already driven: updates the model
    // for the coming rising edge, then checks after it.
    task automatic step();
        logic          acc;
        logic          pop;
        logic [DW-1:0] w;
        acc = req_valid && req_ready_o;
        pop = resp_valid_o && resp_ready;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) begin
                if (req_wen) begin
                    w = mem_m[req_addr];
                    for (int i = 0; i < BW; i++)
                        if (req_be[i]) w[i*8 +: 8] = req_wdata[i*8 +: 8];
                    mem_m[req_addr] = w;
                    exp_q.push_back('{rdata: '0, wen: 1'b1, tag: req_tag});
                end else begin
                    exp_q.push_back('{rdata: mem_m[req_addr], wen: 1'b0, tag: req_tag});
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_req(input logic wen, input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic [DW-1:0] d, input logic [TW-1:0] t);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = a;
        req_be    = b;
        req_wdata = d;
        req_tag   = t;
    endtask

    task automatic do_req(input logic wen, input logic [AW-1:0] a, input logic [BW-1:0] b,
                          input logic [DW-1:0] d, input logic [TW-1:0] t);
        int n;
        n = 0;
        set_req(wen, a, b, d, t);
        while (!req_ready_o && n < 20) begin
            step();
            n++;
        end
        if (!req_ready_o) chk("req_ready_timeout", 64'(req_ready_o), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        int n_acc;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_be     = '0;
        req_wdata  = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o),  64'd1);
        chk("rst_rdata", 64'(resp_rdata_o), 64'd0);

        for (int a = 0; a < 32; a++)
            do_req(1'b1, AW'(a), 4'hF, $urandom, TW'(a));
        do_req(1'b1, 10'h3FF, 4'hF, 32'hAAAAAAAA, 4'd0);
        step();

        do_req(1'b1, 10'h005, 4'hF, 32'hDEADBEEF, 4'd3);
        chk("wr_ack_valid", 64'(resp_valid_o), 64'd1);
        chk("wr_ack_rdata", 64'(resp_rdata_o), 64'd0);
        chk("wr_ack_wen",   64'(resp_wen_o),   64'd1);
        chk("wr_ack_tag",   64'(resp_tag_o),   64'd3);
        do_req(1'b0, 10'h005, 4'h0, 32'h0, 4'd4);
        chk("rd5_rdata", 64'(resp_rdata_o), 64'hDEADBEEF);
        chk("rd5_tag",   64'(resp_tag_o),   64'd4);
        chk("rd5_wen",   64'(resp_wen_o),   64'd0);

        do_req(1'b1, 10'h3FF, 4'b0101, 32'h11223344, 4'd1);
        do_req(1'b0, 10'h3FF, 4'h0, 32'h0, 4'd2);
        chk("merge_rdata", 64'(resp_rdata_o), 64'hAA22AA44);

        for (int i = 0; i < 8; i++) begin
            set_req(1'b0, AW'(i), 4'h0, 32'h0, TW'(i));
            chk("b2b_ready", 64'(req_ready_o), 64'd1);
            step();
            chk("b2b_valid", 64'(resp_valid_o), 64'd1);
            chk("b2b_tag",   64'(resp_tag_o),   64'(i));
        end
        req_valid = 1'b0;

        set_req(1'b1, 10'h010, 4'hF, 32'h12345678, 4'd5);
        chk("raw_wr_ready", 64'(req_ready_o), 64'd1);
        step();
        set_req(1'b0, 10'h010, 4'h0, 32'h0, 4'd6);
        chk("raw_rd_ready", 64'(req_ready_o), 64'd1);
        step();
        req_valid = 1'b0;
        chk("raw_rdata", 64'(resp_rdata_o), 64'h12345678);
        step();

        resp_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            set_req(1'b0, AW'(k), 4'h0, 32'h0, TW'(8 + k));
            if (req_ready_o) n_acc++;
            step();
        end
        req_valid = 1'b0;
        chk("stall_accepted", 64'(n_acc), 64'd2);
        chk("stall_ready",    64'(req_ready_o), 64'd0);
        chk("stall_head_tag", 64'(resp_tag_o), 64'd8);
        resp_ready = 1'b1;
        step();
        chk("drain_ready_back", 64'(req_ready_o), 64'd1);
        chk("drain_next_tag",   64'(resp_tag_o),  64'd9);
        resp_ready = 1'b0;
        do_req(1'b0, 10'h001, 4'h0, 32'h0, 4'd7);
        chk("full_ready", 64'(req_ready_o), 64'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 64'(resp_valid_o), 64'd0);
        chk("midrst_ready", 64'(req_ready_o),  64'd1);
        rst = 1'b1;
        set_req(1'b1, 10'h010, 4'hF, 32'h0BAD0BAD, 4'd1);
        step();
        rst = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        do_req(1'b0, 10'h010, 4'h0, 32'h0, 4'd2);
        chk("post_rst_rd10", 64'(resp_rdata_o), 64'h12345678);
        do_req(1'b0, 10'h005, 4'h0, 32'h0, 4'd3);
        chk("post_rst_rd5",  64'(resp_rdata_o), 64'hDEADBEEF);

        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(99) < 70);
            req_wen    = $urandom_range(1);
            req_addr   = AW'($urandom_range(31));
            req_be     = BW'($urandom);
            req_wdata  = $urandom;
            req_tag    = TW'($urandom);
            resp_ready = ($urandom_range(99) < 65);
            rst        = ($urandom_range(499) == 0);
            step();
        end
        rst       = 1'b0;
        req_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- Memory-side responder for one TCDM bank.
- Accepts word requests (read/write with byte enables) from the bank interconnect over a valid/ready handshake.
- Accesses a flop-based word array with 1-cycle read latency and returns in-order responses over a second valid/ready handshake.
- A small response buffer absorbs response-side backpressure.
- One instance sits behind each bank port; with BankingFactor 4 and 16 KiB per core, each bank holds 4 KiB (1024 words of 32 bits).

Parameters:
- NumWords, 1024, words in the bank; must be a power of two, at least 2.
- DataWidth, 32, data word width; multiple of 8.
- TagWidth, 4, initiator tag width, echoed unchanged in the response.
- RespDepth, 2, response buffer entries; at least 1.
- Derived, not overridable: BeWidth = DataWidth/8; WAddrWidth = $clog2(NumWords).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_addr_i  in  WAddrWidth  word address within the bank
- req_wen_i  in  1  1 = write, 0 = read
- req_be_i  in  BeWidth  byte enables, used on writes only
- req_wdata_i  in  DataWidth  write data
- req_tag_i  in  TagWidth  initiator tag
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid & ready
- resp_rdata_o  out  DataWidth  read data; '0 for write acknowledgements
- resp_wen_o  out  1  echoes req_wen_i of the originating request
- resp_tag_o  out  TagWidth  echoes req_tag_i

Behaviour:
- Reset:
  - On reset, the response buffer is empty, in-flight is cleared, and resp_valid_o = 0.
  - resp_rdata_o, resp_tag_o and resp_wen_o read 0 while the buffer is empty.
  - Word array contents are not reset.
  - Reset mid-operation drops any in-flight access and all buffered responses. A write accepted in the same cycle that rst_i is high is not performed.
- Acceptance rule:
  - req_ready_o = (count + inflight) < RespDepth.
  - count = buffered responses; inflight = 1 if a request was accepted in the previous cycle and is not yet buffered.
  - req_ready_o depends only on registered state, never combinationally on req_valid_i. It must not depend combinationally on resp_ready_i either.
  - A response popped this cycle frees its slot from the next cycle.
- Accepted write:
  - Each byte lane i with req_be_i[i] = 1 is updated at the clock edge of acceptance. Other lanes are unchanged.
  - be = 0 still produces an acknowledgement.
- Accepted read:
  - The word is sampled at the acceptance edge and registered.
  - A read in the cycle after a write to the same address returns the new data.
- Response timing:
  - One cycle after acceptance, the response (rdata, wen, tag) enters the buffer.
  - It is visible on resp_*_o in that same cycle if the buffer was empty.
  - Minimum latency is therefore req handshake at cycle N -> resp_valid_o = 1 at cycle N+1.
- Response buffer:
  - FIFO, strictly in-order, with RespDepth entries and wrapping read/write pointers.
  - Push and pop in the same cycle leaves count unchanged.
  - Outputs come from the buffer head. resp_*_o stay stable while resp_valid_o = 1 and resp_ready_i = 0.
- Full condition: count + inflight = RespDepth gives req_ready_o = 0. Overflow is impossible by construction.
- Simultaneous events: with RespDepth = 2 and resp_ready_i held at 1, the block sustains one request per cycle with no bubbles.
- Assertions (simulation only):
  - No push when full.
  - No pop when empty.
  - req_addr_i is known when req_valid_i = 1.

Test Plan:
- Reset, then write addr 0x005 data 0xDEADBEEF be 0xF tag 3 -> ack at the next cycle with rdata 0, wen 1, tag 3. Read 0x005 tag 4 -> rdata 0xDEADBEEF, tag 4, one cycle after the handshake.
- Partial write addr 0x3FF data 0x11223344 be 0b0101 over prior 0xAAAAAAAA, then read -> 0xAA22AA44. Confirms top-address boundary and byte merging.
- Back-to-back reads to 0x000..0x007 with resp_ready_i = 1 -> eight responses on consecutive cycles, in order, tags matching, req_ready_o never deasserted.
- Hold resp_ready_i = 0 with continuous requests -> exactly 2 accepted, then req_ready_o = 0. Head response stays stable. Raise resp_ready_i -> drains in order, and req_ready_o reasserts the cycle after the first pop.
- Write 0x010 = 0x12345678, then read 0x010 in the immediately following cycle -> 0x12345678.
- Fill the buffer, assert rst_i for 1 cycle -> resp_valid_o = 0 and req_ready_o = 1 next cycle. Earlier completed writes are still readable afterwards.
